// File: rtl/uart_tx_framer_if.sv
// uart_tx_framer_if: start/busy/done request handshake.
// master = upstream command logic, slave = framer.
interface uart_tx_framer_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: one UART frame per accepted request, bit
// timing from rising edges of baud_clk (same clock domain).
// Ports: clock, reset (sync, active-high), baud_clk,
// bus (slave: tx_start/tx_data in, tx_busy/tx_done out), tx.
module uart_tx_framer #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           baud_clk,
  uart_tx_framer_if.slave bus,
  output logic           tx
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_PAR   = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 stop_q, stop_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 baud_q;
  logic                 tick;

  // one clock wide on each rising edge of baud_clk
  assign tick = baud_clk & ~baud_q;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.tx_start) begin
          sh_d    = bus.tx_data;
          par_d   = (PARITY == 2) ? ~^bus.tx_data
                                  : ^bus.tx_data;
          busy_d  = 1'b1;
          state_d = S_ARMED;
        end
      end
      // a tick in the acceptance cycle is skipped so the
      // start bit always spans a full baud period
      S_ARMED: begin
        if (tick) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          tx_d    = sh_q[0];
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (cnt_q == LAST_BIT) begin
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = S_PAR;
            end else begin
              tx_d    = 1'b1;
              stop_d  = 1'b0;
              state_d = S_STOP;
            end
          end else begin
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_PAR: begin
        if (tick) begin
          tx_d    = 1'b1;
          stop_d  = 1'b0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (stop_q == LAST_STOP) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      baud_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      baud_q  <= baud_clk;
    end
  end

  assign tx          = tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: directed bench with a frame scoreboard
// for four framer configurations sharing one baud source.
module tb_uart_tx_framer;

  localparam int HB  = 4;
  localparam int PER = 2 * HB;

  typedef struct {
    logic [11:0] bits;
    int          len;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_clk = 1'b0;
  logic       bd_run;
  int         bcnt = 0;
  logic [3:0] start_v;
  logic [7:0] tx_data;
  logic [1:0] sel;
  logic [3:0] tx_w, busy_w, done_w;
  logic       tx_s, busy_s, done_s;
  logic       prev_b = 1'b0;
  logic       tick_r = 1'b0;
  logic       rst_r = 1'b1;

  int     n_tests;
  int     n_fail;
  int     dones;
  int     mon_idx;
  int     gap;
  logic   act;
  logic   chk_gap;
  frame_t exp_q[$];

  uart_tx_framer_if #(.DATA_BITS(8)) if0 ();
  uart_tx_framer_if #(.DATA_BITS(8)) if1 ();
  uart_tx_framer_if #(.DATA_BITS(8)) if2 ();
  uart_tx_framer_if #(.DATA_BITS(8)) if3 ();

  assign if0.tx_start = start_v[0];
  assign if1.tx_start = start_v[1];
  assign if2.tx_start = start_v[2];
  assign if3.tx_start = start_v[3];
  assign if0.tx_data  = tx_data;
  assign if1.tx_data  = tx_data;
  assign if2.tx_data  = tx_data;
  assign if3.tx_data  = tx_data;
  assign busy_w = {if3.tx_busy, if2.tx_busy,
                   if1.tx_busy, if0.tx_busy};
  assign done_w = {if3.tx_done, if2.tx_done,
                   if1.tx_done, if0.tx_done};
  assign tx_s   = tx_w[sel];
  assign busy_s = busy_w[sel];
  assign done_s = done_w[sel];

  uart_tx_framer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clock(clk), .reset(reset), .baud_clk(baud_clk),
    .bus(if0), .tx(tx_w[0]));
  uart_tx_framer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clock(clk), .reset(reset), .baud_clk(baud_clk),
    .bus(if1), .tx(tx_w[1]));
  uart_tx_framer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
    .clock(clk), .reset(reset), .baud_clk(baud_clk),
    .bus(if2), .tx(tx_w[2]));
  uart_tx_framer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u3 (
    .clock(clk), .reset(reset), .baud_clk(baud_clk),
    .bus(if3), .tx(tx_w[3]));

  always #5 clk = ~clk;

  // baud generator: square wave, period PER clocks
  always @(posedge clk) begin
    if (bd_run) begin
      if (bcnt == HB - 1) begin
        bcnt     <= 0;
        baud_clk <= ~baud_clk;
      end else begin
        bcnt <= bcnt + 1;
      end
    end
  end

  // tick_r: a baud tick was seen at the last clock edge
  always @(posedge clk) begin
    tick_r <= baud_clk & ~prev_b;
    prev_b <= reset ? 1'b0 : baud_clk;
    rst_r  <= reset;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic frame_t make_frame(input logic [7:0] d,
                                        input int par,
                                        input int stops);
    frame_t f;
    int n;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1 + i] = d[i];
    n = 9;
    if (par != 0) begin
      f.bits[9] = (par == 1) ? ^d : ~^d;
      n = 10;
    end
    f.len = n + stops;
    return f;
  endfunction

  function automatic int par_of(input logic [1:0] k);
    return (k == 2'd1) ? 1 : (k == 2'd2) ? 2 : 0;
  endfunction

  function automatic int stops_of(input logic [1:0] k);
    return (k == 2'd3) ? 2 : 1;
  endfunction

  task automatic monitor();
    frame_t cur;
    cur.bits = '1;
    cur.len  = 0;
    forever begin
      @(negedge clk);
      if (rst_r) begin
        act     = 1'b0;
        mon_idx = 0;
        chk("rst_tx", 32'(tx_s), 1);
        chk("rst_busy", 32'(busy_s), 0);
        chk("rst_done", 32'(done_s), 0);
      end else if (!act) begin
        gap++;
        chk("idle_done", 32'(done_s), 0);
        if (tx_s !== 1'b1) begin
          chk("start_on_tick", 32'(tick_r), 1);
          chk("frame_expected", 32'(exp_q.size() > 0), 1);
          if (chk_gap) chk("b2b_gap", 32'(gap <= PER), 1);
          if (exp_q.size() > 0) begin
            cur     = exp_q.pop_front();
            act     = 1'b1;
            mon_idx = 0;
          end
        end
      end else begin
        if (tick_r) mon_idx++;
        if (mon_idx >= cur.len) begin
          chk("end_done", 32'(done_s), 1);
          chk("end_busy", 32'(busy_s), 0);
          chk("end_tx", 32'(tx_s), 1);
          dones++;
          act = 1'b0;
          gap = 0;
        end else begin
          chk("bit", 32'(tx_s), 32'(cur.bits[mon_idx]));
          chk("mid_done", 32'(done_s), 0);
          chk("mid_busy", 32'(busy_s), 1);
        end
      end
    end
  endtask

  task automatic send(input logic [1:0] k,
                      input logic [7:0] d);
    @(negedge clk);
    sel        = k;
    tx_data    = d;
    start_v    = 4'b0;
    start_v[k] = 1'b1;
    exp_q.push_back(make_frame(d, par_of(k), stops_of(k)));
    chk("busy_pre", 32'(busy_s), 0);
    @(negedge clk);
    chk("busy_post", 32'(busy_s), 1);
    start_v = 4'b0;
  endtask

  task automatic wait_dones(input int target);
    int c = 0;
    while (dones < target && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("timeout_done", 32'(dones >= target), 1);
  endtask

  task automatic wait_idx(input int k);
    int c = 0;
    while (!(act && mon_idx == k) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("timeout_idx", 32'(mon_idx), 32'(k));
  endtask

  task automatic wait_busy();
    int c = 0;
    while (busy_s !== 1'b1 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("timeout_busy", 32'(busy_s), 1);
  endtask

  initial begin
    int base;
    n_tests = 0;
    n_fail  = 0;
    dones   = 0;
    mon_idx = 0;
    gap     = 0;
    act     = 1'b0;
    chk_gap = 1'b0;
    reset   = 1'b1;
    bd_run  = 1'b1;
    sel     = 2'd0;
    tx_data = 8'hA5;
    start_v = 4'b0001;
    fork
      monitor();
    join_none

    // reset with request held: first accept right after
    repeat (3) @(negedge clk);
    chk("rst_hold_busy", 32'(busy_s), 0);
    reset = 1'b0;
    exp_q.push_back(make_frame(8'hA5, 0, 1));
    @(negedge clk);
    chk("first_accept", 32'(busy_s), 1);
    start_v = 4'b0;
    wait_dones(1);

    // basic frame 0xA5
    send(2'd0, 8'hA5);
    wait_dones(2);

    // parity variants
    send(2'd1, 8'hA5);
    wait_dones(3);
    send(2'd2, 8'hA5);
    wait_dones(4);
    send(2'd1, 8'h07);
    wait_dones(5);

    // baud stalled mid-frame: line holds
    send(2'd0, 8'h3C);
    wait_idx(3);
    bd_run = 1'b0;
    repeat (5 * PER) @(negedge clk);
    chk("stall_busy", 32'(busy_s), 1);
    chk("stall_idx", 32'(mon_idx), 3);
    bd_run = 1'b1;
    wait_dones(6);

    // request mid-frame is ignored
    send(2'd0, 8'hA5);
    wait_idx(3);
    tx_data    = 8'h3C;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v = 4'b0;
    wait_dones(7);
    repeat (4 * PER) @(negedge clk);
    chk("ign_dones", 32'(dones), 7);
    chk("ign_queue", 32'(exp_q.size()), 0);
    chk("ign_busy", 32'(busy_s), 0);

    // back-to-back, two stop bits
    @(negedge clk);
    sel     = 2'd3;
    tx_data = 8'h55;
    start_v = 4'b1000;
    exp_q.push_back(make_frame(8'h55, 0, 2));
    @(negedge clk);
    wait_busy();
    tx_data = 8'h00;
    exp_q.push_back(make_frame(8'h00, 0, 2));
    wait_dones(8);
    chk_gap = 1'b1;
    wait_busy();
    start_v = 4'b0;
    wait_dones(9);
    chk_gap = 1'b0;
    repeat (4 * PER) @(negedge clk);
    chk("b2b_dones", 32'(dones), 9);

    // reset during data bit 3 aborts the frame
    send(2'd0, 8'h5A);
    wait_idx(4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_tx", 32'(tx_s), 1);
    chk("abort_busy", 32'(busy_s), 0);
    base = dones;
    repeat (3 * PER) @(negedge clk);
    chk("abort_no_done", 32'(dones), 32'(base));
    send(2'd0, 8'hFF);
    wait_dones(base + 1);

    repeat (2 * PER) @(negedge clk);
    chk("final_queue", 32'(exp_q.size()), 0);
    chk("final_dones", 32'(dones), 32'(base + 1));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
